// File: rtl/spi_flash_arb_pkg.sv
// Shared types and constants for the SPI configuration flash arbiter.
// Holds the FSM state enum, grant bit indices and default parameter values.
package spi_flash_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_GRANT_DSP = 2'd1,
        ST_GRANT_CPU = 2'd2,
        ST_GUARD     = 2'd3
    } state_t;

    localparam int GNT_DSP = 0;
    localparam int GNT_CPU = 1;

    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_GUARD_CYCLES   = 16;
    localparam int DEF_TIMEOUT_CYCLES = 1048576;

    // Width of a down/up counter that must hold values 0 .. n-1.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// N-stage single-bit synchronizer with a selectable reset value.
// Used on each master chip-select so that no request appears out of reset.
module sync_bit #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_flash_arbiter.sv
// Round-robin owner selection for the shared SPI flash between DSP and CPU.
// Optional grant timeout with lockout: define SPI_FLASH_ARB_TIMEOUT_EN.
module spi_flash_arbiter
    import spi_flash_arb_pkg::*;
#(
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int GUARD_CYCLES   = DEF_GUARD_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       sysclk,
    input  logic       reset_INV,
    input  logic       enable,
    input  logic       dsp_cs_INV,
    input  logic       dsp_clk,
    input  logic       dsp_mosi,
    output logic       dsp_miso,
    input  logic       cpu_cs_INV,
    input  logic       cpu_clk,
    input  logic       cpu_mosi,
    output logic       cpu_miso,
    output logic       flash_cs_INV,
    output logic       flash_clk,
    output logic       flash_mosi,
    input  logic       flash_miso,
    output logic [1:0] grant,
    output logic       busy,
    output logic       timeout
);

    localparam int GW = cnt_width(GUARD_CYCLES);

    state_t          state;
    state_t          state_next;
    logic            last;
    logic [GW-1:0]   guard_cnt;
    logic            dsp_cs_sync;
    logic            cpu_cs_sync;
    logic            req_dsp;
    logic            req_cpu;
    logic            req_dsp_ok;
    logic            req_cpu_ok;
    logic            force_out;

    sync_bit #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync_dsp (
        .clk   (sysclk),
        .rst_n (reset_INV),
        .d     (dsp_cs_INV),
        .q     (dsp_cs_sync)
    );

    sync_bit #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync_cpu (
        .clk   (sysclk),
        .rst_n (reset_INV),
        .d     (cpu_cs_INV),
        .q     (cpu_cs_sync)
    );

    assign req_dsp = ~dsp_cs_sync;
    assign req_cpu = ~cpu_cs_sync;

`ifdef SPI_FLASH_ARB_TIMEOUT_EN
    localparam int TW = cnt_width(TIMEOUT_CYCLES);

    logic [TW-1:0] grant_cnt;
    logic          lock_dsp;
    logic          lock_cpu;
    logic          timeout_q;
    logic          owner_keep;

    assign owner_keep = enable &&
        ((state == ST_GRANT_DSP && req_dsp) ||
         (state == ST_GRANT_CPU && req_cpu));
    assign force_out  = owner_keep &&
        (grant_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Grant length counter; every grant is entered from IDLE, so clearing there starts each grant at 0.
    always_ff @(posedge sysclk or negedge reset_INV) begin
        if (!reset_INV) begin
            grant_cnt <= '0;
        end else if (state == ST_IDLE) begin
            grant_cnt <= '0;
        end else if (state == ST_GRANT_DSP || state == ST_GRANT_CPU) begin
            grant_cnt <= grant_cnt + 1'b1;
        end
    end

    // A revoked master stays locked out until its synchronized CS is seen released.
    always_ff @(posedge sysclk or negedge reset_INV) begin
        if (!reset_INV) begin
            lock_dsp  <= 1'b0;
            lock_cpu  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= force_out;
            if (force_out && state == ST_GRANT_DSP) begin
                lock_dsp <= 1'b1;
            end else if (!req_dsp) begin
                lock_dsp <= 1'b0;
            end
            if (force_out && state == ST_GRANT_CPU) begin
                lock_cpu <= 1'b1;
            end else if (!req_cpu) begin
                lock_cpu <= 1'b0;
            end
        end
    end

    assign req_dsp_ok = req_dsp & ~lock_dsp;
    assign req_cpu_ok = req_cpu & ~lock_cpu;
    assign timeout    = timeout_q;
`else
    logic unused_timeout_cfg;

    // Keeps the timeout length referenced in builds without the timeout logic.
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign force_out  = 1'b0;
    assign req_dsp_ok = req_dsp;
    assign req_cpu_ok = req_cpu;
    assign timeout    = 1'b0;
`endif

    // State register.
    always_ff @(posedge sysclk or negedge reset_INV) begin
        if (!reset_INV) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Guard countdown and round-robin memory of the last owner.
    always_ff @(posedge sysclk or negedge reset_INV) begin
        if (!reset_INV) begin
            guard_cnt <= '0;
            last      <= 1'(GNT_CPU);
        end else begin
            if (state != ST_GUARD && state_next == ST_GUARD) begin
                guard_cnt <= GW'(GUARD_CYCLES - 1);
            end else if (state == ST_GUARD && guard_cnt != '0) begin
                guard_cnt <= guard_cnt - 1'b1;
            end
            if (state == ST_IDLE && state_next == ST_GRANT_DSP) begin
                last <= 1'(GNT_DSP);
            end else if (state == ST_IDLE && state_next == ST_GRANT_CPU) begin
                last <= 1'(GNT_CPU);
            end
        end
    end

    // Next-state: ties go to the master that did not own the flash last.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (enable) begin
                    if (req_dsp_ok && req_cpu_ok) begin
                        state_next = (last == 1'(GNT_DSP)) ?
                            ST_GRANT_CPU : ST_GRANT_DSP;
                    end else if (req_dsp_ok) begin
                        state_next = ST_GRANT_DSP;
                    end else if (req_cpu_ok) begin
                        state_next = ST_GRANT_CPU;
                    end
                end
            end
            ST_GRANT_DSP: begin
                if (!req_dsp || !enable || force_out) begin
                    state_next = ST_GUARD;
                end
            end
            ST_GRANT_CPU: begin
                if (!req_cpu || !enable || force_out) begin
                    state_next = ST_GUARD;
                end
            end
            ST_GUARD: begin
                if (guard_cnt == '0) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded straight from the state flops.
    always_comb begin
        grant          = 2'b00;
        grant[GNT_DSP] = (state == ST_GRANT_DSP);
        grant[GNT_CPU] = (state == ST_GRANT_CPU);
        busy           = (state != ST_IDLE);
    end

    // SPI mux; SCK passes through untouched, idle pins park deselected.
    always_comb begin
        flash_cs_INV = 1'b1;
        flash_clk    = 1'b0;
        flash_mosi   = 1'b0;
        dsp_miso     = 1'b0;
        cpu_miso     = 1'b0;
        unique case (1'b1)
            grant[GNT_DSP]: begin
                flash_cs_INV = dsp_cs_INV;
                flash_clk    = dsp_clk;
                flash_mosi   = dsp_mosi;
                dsp_miso     = flash_miso;
            end
            grant[GNT_CPU]: begin
                flash_cs_INV = cpu_cs_INV;
                flash_clk    = cpu_clk;
                flash_mosi   = cpu_mosi;
                cpu_miso     = flash_miso;
            end
            default: begin
            end
        endcase
    end

endmodule
